// File: rtl/matmul_host_sequencer.sv
// Host-side initiator for the matrix accelerator: streams a buffered X operand
// vector over the load interface, then collects result words until finish.
module matmul_host_sequencer #(
  parameter int unsigned X_DEPTH = 32,
  parameter int unsigned X_AW    = 5,
  parameter int unsigned R_DEPTH = 16,
  parameter int unsigned R_AW    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_go,
  input  logic              x_wr_en,
  input  logic [X_AW-1:0]   x_wr_addr,
  input  logic [7:0]        x_wr_data,
  input  logic [R_AW-1:0]   res_rd_addr,
  output logic [31:0]       res_rd_data,
  output logic [R_AW:0]     res_count,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_overflow,
  output logic              start_in,
  output logic              valid_input,
  output logic [7:0]        X_load,
  output logic              cs_n,
  input  logic              ry,
  input  logic [31:0]       read_data,
  input  logic              finish
);

  localparam int unsigned RCW = R_AW + 1;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [7:0]  xbuf [X_DEPTH];
  logic [31:0] rbuf [R_DEPTH];

  logic [X_AW-1:0] idx, idx_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [RCW-1:0]  res_count_d;
  logic            err_timeout_d, err_overflow_d;
  logic            start_in_d, valid_input_d, cs_n_d, busy_d, done_d;
  logic [7:0]      x_load_d;
  logic            rbuf_we_c;
  logic [R_AW-1:0] rbuf_waddr_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (cmd_go) next_state = S_START;
      S_START:   next_state = S_LOAD;
      S_LOAD:    if (idx == X_AW'(X_DEPTH - 1)) next_state = S_COLLECT;
      S_COLLECT: if (finish || (tcnt == TW'(TIMEOUT - 1))) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output/datapath next values; outputs follow the state being entered
  always_comb begin
    idx_d          = idx;
    tcnt_d         = tcnt;
    res_count_d    = res_count;
    err_timeout_d  = err_timeout;
    err_overflow_d = err_overflow;
    x_load_d       = X_load;
    rbuf_we_c      = 1'b0;
    rbuf_waddr_c   = res_count[R_AW-1:0];

    case (state)
      S_IDLE: begin
        if (cmd_go) begin
          res_count_d    = '0;
          err_timeout_d  = 1'b0;
          err_overflow_d = 1'b0;
        end
      end
      S_START: idx_d = '0;
      S_LOAD: begin
        if (idx != X_AW'(X_DEPTH - 1)) idx_d = idx + X_AW'(1);
        tcnt_d = '0;
      end
      S_COLLECT: begin
        tcnt_d = tcnt + TW'(1);
        if (ry) begin
          if (res_count < RCW'(R_DEPTH)) begin
            rbuf_we_c   = 1'b1;
            res_count_d = res_count + RCW'(1);
          end else begin
            err_overflow_d = 1'b1;
          end
        end
        if (!finish && (tcnt == TW'(TIMEOUT - 1))) err_timeout_d = 1'b1;
      end
      default: ;
    endcase

    if (next_state == S_LOAD) x_load_d = xbuf[idx_d];

    start_in_d    = (next_state == S_START);
    valid_input_d = (next_state == S_LOAD);
    cs_n_d        = (next_state != S_COLLECT);
    busy_d        = (next_state != S_IDLE);
    done_d        = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      tcnt         <= '0;
      res_count    <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      start_in     <= 1'b0;
      valid_input  <= 1'b0;
      X_load       <= '0;
      cs_n         <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      idx          <= idx_d;
      tcnt         <= tcnt_d;
      res_count    <= res_count_d;
      err_timeout  <= err_timeout_d;
      err_overflow <= err_overflow_d;
      start_in     <= start_in_d;
      valid_input  <= valid_input_d;
      X_load       <= x_load_d;
      cs_n         <= cs_n_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // X operand buffer: host writes only land while idle
  always_ff @(posedge clk) begin
    if (x_wr_en && (state == S_IDLE)) xbuf[x_wr_addr] <= x_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rbuf_we_c) rbuf[rbuf_waddr_c] <= read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) res_rd_data <= '0;
    else     res_rd_data <= rbuf[res_rd_addr];
  end

endmodule

// File: doc/matmul_host_sequencer.md
Name: matmul_host_sequencer

Overview:
- Host-side initiator for the matrix accelerator top level. Holds a byte buffer of X operands and, on command, drives the accelerator's load interface: start_in, valid_input, X_load, cs_n.
- Waits for finish and, in the same pass, collects every 32-bit read_data word flagged by ry into a result buffer that the host can read back.
- Sits between the test/host logic and the accelerator; the accelerator ports connect 1:1.

Parameters:
- X_DEPTH, 32, number of X bytes streamed per run.
- X_AW, 5, X buffer address width (must equal clog2(X_DEPTH)).
- R_DEPTH, 16, result buffer depth in 32-bit words.
- R_AW, 4, result buffer address width (must equal clog2(R_DEPTH)).
- TIMEOUT, 4096, maximum cycles in COLLECT before abort.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_go  in  1  one-cycle run request
- x_wr_en  in  1  X buffer write strobe
- x_wr_addr  in  X_AW  X buffer write address
- x_wr_data  in  8  X buffer write data
- res_rd_addr  in  R_AW  result buffer read address
- res_rd_data  out  32  result word; registered, valid 1 cycle after address
- res_count  out  R_AW+1  words captured in last run
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of run
- err_timeout  out  1  sticky: last run aborted by timeout
- err_overflow  out  1  sticky: last run produced more than R_DEPTH words
- start_in  out  1  to accelerator
- valid_input  out  1  to accelerator
- X_load  out  8  to accelerator
- cs_n  out  1  to accelerator, active-low read select
- ry  in  1  from accelerator; read_data valid
- read_data  in  32  from accelerator
- finish  in  1  from accelerator; run complete

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; start_in=0, valid_input=0, X_load=0, cs_n=1.
  - busy=0, done=0, err_timeout=0, err_overflow=0, res_count=0, res_rd_data=0.
  - Buffer contents are not reset.
- All accelerator-side outputs are registered.
- X buffer writes:
  - Accepted only in IDLE; ignored while busy.
  - A write and cmd_go in the same cycle: the write lands first, and that byte is used by the run.
- State machine:
  - IDLE: cmd_go=1 -> START. Clear res_count, err_timeout and err_overflow.
  - START: start_in=1 for exactly one cycle; load index=0 -> LOAD.
  - LOAD: valid_input=1 and X_load=xbuf[index] for X_DEPTH consecutive cycles, index 0..X_DEPTH-1, no gaps. After the last byte -> COLLECT. valid_input drops to 0 and X_load holds the last value.
  - COLLECT: cs_n=0; timeout counter increments every cycle.
    - ry=1: capture read_data into rbuf[res_count] and increment res_count, only if res_count<R_DEPTH.
    - ry=1 with res_count already at R_DEPTH: word dropped, err_overflow=1.
    - finish=1 -> DONE. An ry word in that same cycle is still captured.
    - Counter reaching TIMEOUT-1 without finish: err_timeout=1 -> DONE.
  - DONE: cs_n=1, done=1 for one cycle -> IDLE.
- ry or finish arriving in IDLE, START or LOAD is ignored; nothing is captured.
- cmd_go while busy is ignored.
- res_rd_data = rbuf[res_rd_addr], registered, 1-cycle latency, readable in any state.
- rst mid-run: returns to IDLE next cycle and all accelerator outputs are deasserted. res_count is cleared; rbuf is untouched.
- Latency: cmd_go at cycle 0 -> start_in at cycle 1 -> first valid_input at cycle 2 -> last byte at cycle X_DEPTH+1 -> COLLECT from cycle X_DEPTH+2.

Test Plan:
- Reset, then idle 10 cycles -> cs_n=1; start_in, valid_input, busy and done all 0; res_count=0.
- Write bytes 0x00..0x1F, then cmd_go -> start_in pulses one cycle; then 32 consecutive valid_input cycles with X_load 0x00..0x1F in order.
- Model responds with ry on 4 words 0xDEADBEEF, 0x1, 0x2, 0x3, then finish coincident with a fifth word 0x4 -> res_count=5, rbuf[0..4] match, done pulses once, no error flags.
- Model issues 18 ry words, then finish -> res_count=16, words 17 and 18 dropped, err_overflow=1.
- Model never asserts finish, TIMEOUT=64 -> DONE 64 cycles after COLLECT entry; err_timeout=1; cs_n returns to 1.
- Assert rst in the middle of LOAD, then cmd_go after X buffer rewrite -> outputs idle after reset; the new run streams the new bytes from index 0.
